// File: rtl/sub_borrow_seq_nbits.sv
// sub_borrow_seq_nbits: multi-cycle LSB-first subtractor, chunk bits per clock with a chained borrow flop.
module sub_borrow_seq_nbits #(
    parameter int width = 8,
    parameter int chunk = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] d_o,
    output logic             bout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);
    localparam int N  = width / chunk;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [width-1:0] r_a, r_b, r_d;
    logic             r_borrow, r_am, r_bm;
    logic [CW-1:0]    r_cnt;
    logic [chunk:0]   w_diff;
    logic [width-1:0] w_d;
    assign w_diff = {1'b0, r_a[chunk-1:0]} - {1'b0, r_b[chunk-1:0]} - {{chunk{1'b0}}, r_borrow};
    // New chunk enters the result register from the MSB side.
    assign w_d    = (r_d >> chunk) | (width'(w_diff[chunk-1:0]) << (width - chunk));
    assign busy_o = r_state == RUN;
    assign done_o = r_state == DONE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_am     <= 1'b0;
            r_bm     <= 1'b0;
            r_cnt    <= '0;
            d_o      <= '0;
            bout_o   <= 1'b0;
            ovf_o    <= 1'b0;
            zero_o   <= 1'b0;
            neg_o    <= 1'b0;
        end else if (r_state != RUN && start_i) begin
            r_state  <= RUN;
            r_a      <= a_i;
            r_b      <= b_i;
            r_am     <= a_i[width-1];
            r_bm     <= b_i[width-1];
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> chunk;
            r_b      <= r_b >> chunk;
            r_d      <= w_d;
            r_borrow <= w_diff[chunk];
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(N - 1)) begin
                r_state <= DONE;
                d_o     <= w_d;
                bout_o  <= w_diff[chunk];
                ovf_o   <= (r_am ^ r_bm) & (w_d[width-1] ^ r_am);
                zero_o  <= ~|w_d;
                neg_o   <= w_d[width-1];
            end
        end else begin
            r_state <= IDLE;
        end
    end
endmodule
